// File: rtl/fib_sequencer.sv
// fib_sequencer: Wishbone-controlled run sequencer for the fibonacci datapath.
// Software programs COUNT and starts a run. The block clears the datapath,
// steps it COUNT times, captures the term, and reports done/overflow.
module fib_sequencer #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic             fib_clear,
  output logic             fib_step,
  input  logic [WIDTH-1:0] fib_value,
  output logic             busy,
  output logic             done_irq
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_RUN     = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  // Bus-side registers
  logic             r_ack;
  logic [31:0]      r_rdata;
  logic [15:0]      r_count;
  logic             r_irq_en;

  // Sequencer registers
  state_t           r_state;
  logic [15:0]      r_run_count;
  logic [15:0]      r_steps;
  logic [31:0]      r_result;
  logic             r_done;
  logic             r_ovf;
  logic             r_busy;
  logic             r_fib_clear;
  logic             r_fib_step;
  logic [WIDTH-1:0] r_prev;

  // Address decode and write strobes
  logic [31:0] w_off;
  logic [2:0]  w_idx;
  logic        w_hit;
  logic        w_req;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_count;
  logic        w_wr_status;
  logic        w_start;
  logic        w_abort;
  logic        w_clr_done;
  logic        w_clr_ovf;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_off       = wbs_adr_i - BASE_ADDR;
  assign w_idx       = w_off[4:2];
  // Only word-aligned offsets 0x00..0x1C land in the register window
  assign w_hit       = (w_off[31:5] == 27'd0) && (w_off[1:0] == 2'b00);
  // A new transfer is accepted only while ack is low, giving one-cycle acks
  assign w_req       = wbs_stb_i & wbs_cyc_i & ~r_ack;
  assign w_wr        = w_req & wbs_we_i;
  assign w_wr_ctrl   = w_wr & w_hit & (w_idx == 3'd0);
  assign w_wr_count  = w_wr & w_hit & (w_idx == 3'd1);
  assign w_wr_status = w_wr & w_hit & (w_idx == 3'd2);
  // Abort dominates a simultaneous start
  assign w_start     = w_wr_ctrl & wbs_dat_i[0] & ~wbs_dat_i[1];
  assign w_abort     = w_wr_ctrl & wbs_dat_i[1];
  assign w_clr_done  = w_wr_status & wbs_dat_i[1];
  assign w_clr_ovf   = w_wr_status & wbs_dat_i[2];
  // Byte selects are ignored (full-word writes) and upper data bits have no home
  assign w_unused    = &{1'b0, wbs_sel_i, wbs_dat_i[31:16]};

  // Read data multiplexer; unmapped offsets read as zero
  always_comb begin
    w_rdata = 32'd0;
    if (w_hit) begin
      case (w_idx)
        3'd0:    w_rdata = {29'd0, r_irq_en, 2'b00};
        3'd1:    w_rdata = {16'd0, r_count};
        3'd2:    w_rdata = {29'd0, r_ovf, r_done, r_busy};
        3'd3:    w_rdata = r_result;
        3'd4:    w_rdata = {16'd0, r_steps};
        default: w_rdata = 32'd0;
      endcase
    end
  end

  // Wishbone handshake, read data register and software-owned config
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack    <= 1'b0;
      r_rdata  <= 32'd0;
      r_count  <= 16'd0;
      r_irq_en <= 1'b0;
    end else begin
      r_ack   <= w_req;
      r_rdata <= (w_req & ~wbs_we_i) ? w_rdata : 32'd0;
      if (w_wr_ctrl)  r_irq_en <= wbs_dat_i[2];
      if (w_wr_count) r_count  <= wbs_dat_i[15:0];
    end
  end

  // Run FSM with registered datapath controls, status and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_run_count <= 16'd0;
      r_steps     <= 16'd0;
      r_result    <= 32'd0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_busy      <= 1'b0;
      r_fib_clear <= 1'b0;
      r_fib_step  <= 1'b0;
      r_prev      <= '0;
    end else begin
      // The datapath reads 0 right after the clear, so the history restarts at 0
      r_prev <= (r_state == ST_CLEAR) ? '0 : fib_value;
      if (w_clr_done) r_done <= 1'b0;
      if (w_clr_ovf)  r_ovf  <= 1'b0;
      // Fibonacci never decreases, so any drop is a wrap; set beats W1C
      if (((r_state == ST_RUN) || (r_state == ST_CAPTURE)) && (fib_value < r_prev))
        r_ovf <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_CLEAR;
            r_run_count <= r_count;
            r_steps     <= 16'd0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b1;
            r_fib_clear <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_fib_clear <= 1'b0;
          if (w_abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_run_count == 16'd0) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_state    <= ST_RUN;
            r_fib_step <= 1'b1;
          end
        end
        ST_RUN: begin
          // The step driven this cycle lands regardless of an abort, so count it
          r_steps <= r_steps + 16'd1;
          if (w_abort) begin
            r_state    <= ST_IDLE;
            r_fib_step <= 1'b0;
            r_busy     <= 1'b0;
          end else if (r_steps + 16'd1 == r_run_count) begin
            r_state    <= ST_CAPTURE;
            r_fib_step <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          if (!w_abort) begin
            r_result <= 32'(fib_value);
            r_done   <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_rdata;
  assign fib_clear = r_fib_clear;
  assign fib_step  = r_fib_step;
  assign busy      = r_busy;
  assign done_irq  = r_done & r_irq_en;

endmodule

// File: tb/tb_fib_sequencer.sv
// Testbench for fib_sequencer: behavioural fibonacci datapath plus an exact
// arithmetic reference for RESULT/overflow, directed and random runs.
module tb_fib_sequencer;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = 32'h00;
  localparam logic [31:0] A_CNT  = 32'h04;
  localparam logic [31:0] A_STAT = 32'h08;
  localparam logic [31:0] A_RES  = 32'h0C;
  localparam logic [31:0] A_STEP = 32'h10;

  logic        clk = 1'b0;
  logic        reset;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        fib_clear, fib_step, busy, done_irq;
  logic [31:0] dp_val = 32'd0;
  logic [31:0] dp_nxt = 32'd1;

  int n_pass  = 0;
  int n_total = 0;
  int busy_cnt = 0;
  int step_cnt = 0;
  int clr_cnt  = 0;

  fib_sequencer #(.WIDTH(32), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .fib_clear (fib_clear),
    .fib_step  (fib_step),
    .fib_value (dp_val),
    .busy      (busy),
    .done_irq  (done_irq)
  );

  always #5 clk = ~clk;

  // Fibonacci datapath the sequencer drives
  always @(posedge clk) begin
    if (fib_clear) begin
      dp_val <= 32'd0;
      dp_nxt <= 32'd1;
    end else if (fib_step) begin
      dp_val <= dp_nxt;
      dp_nxt <= dp_val + dp_nxt;
    end
  end

  // Cycle counters for control outputs
  always @(posedge clk) begin
    if (busy)      busy_cnt <= busy_cnt + 1;
    if (fib_step)  step_cnt <= step_cnt + 1;
    if (fib_clear) clr_cnt  <= clr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Exact Fibonacci in 64 bits; 32-bit datapath view is the low word
  task automatic fib_ref(input int n, output logic [31:0] res, output logic ovf);
    longint unsigned f [0:95];
    f[0] = 0;
    f[1] = 1;
    for (int i = 2; i <= n; i++) f[i] = f[i-1] + f[i-2];
    ovf = 1'b0;
    for (int i = 1; i <= n; i++)
      if (f[i][31:0] < f[i-1][31:0]) ovf = 1'b1;
    res = f[n][31:0];
  endtask

  // One Wishbone transfer; called away from the clock edge
  task automatic wb_xfer(input logic we, input logic [31:0] off, input logic [31:0] wdat,
                         output logic [31:0] rdat);
    logic acked;
    acked = 1'b0;
    rdat  = 32'd0;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = BASE + off;
    wbs_dat_i = wdat;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(posedge clk);
      #1;
      if (wbs_ack_o) begin
        acked = 1'b1;
        rdat  = wbs_dat_o;
      end
    end
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    check("wb_ack", {31'd0, acked}, 32'd1);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    logic [31:0] unused_rd;
    wb_xfer(1'b1, off, d, unused_rd);
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] d);
    wb_xfer(1'b0, off, 32'd0, d);
  endtask

  task automatic wait_idle(input string tag);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(posedge clk);
      #1;
      if (!busy) idle = 1'b1;
    end
    if (!idle) check({tag, "_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  // Program COUNT, start, check run shape and registers against the model
  task automatic run_check(input int n, input logic irq, input string tag);
    int b0, s0, c0;
    logic [31:0] v, exp_res;
    logic exp_ovf;
    wr(A_CNT, n);
    b0 = busy_cnt; s0 = step_cnt; c0 = clr_cnt;
    wr(A_CTRL, {29'd0, irq, 2'b01});
    check({tag, "_busy_at_start"}, {31'd0, busy}, 32'd1);
    check({tag, "_clear_at_start"}, {31'd0, fib_clear}, 32'd1);
    wait_idle(tag);
    check({tag, "_irq"}, {31'd0, done_irq}, {31'd0, irq});
    check({tag, "_steps_seen"}, step_cnt - s0, n);
    check({tag, "_busy_cycles"}, busy_cnt - b0, n + 2);
    check({tag, "_clear_pulses"}, clr_cnt - c0, 32'd1);
    fib_ref(n, exp_res, exp_ovf);
    rd(A_RES, v);  check({tag, "_result"}, v, exp_res);
    rd(A_STEP, v); check({tag, "_steps_reg"}, v, n);
    rd(A_STAT, v); check({tag, "_status"}, v, {29'd0, exp_ovf, 2'b10});
    $display("run %s: count=%0d result=%0d ovf=%0b", tag, n, exp_res, exp_ovf);
  endtask

  initial begin
    logic [31:0] v, rnd;
    int n, b0, s0, c0, lim;

    reset = 1'b1;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; wbs_adr_i = 32'd0; wbs_dat_i = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    check("rst_clear", {31'd0, fib_clear}, 32'd0);
    check("rst_step", {31'd0, fib_step}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_irq", {31'd0, done_irq}, 32'd0);

    // Directed runs
    run_check(10, 1'b0, "n10");
    check("n10_result_const", dut.r_result, 32'd55);
    run_check(0, 1'b0, "n0");
    run_check(47, 1'b0, "n47");
    rd(A_RES, v); check("n47_result_const", v, 32'd2971215073);
    run_check(48, 1'b0, "n48");
    rd(A_RES, v); check("n48_result_const", v, 32'd512559680);
    rd(A_STAT, v); check("n48_ovf_const", v, 32'h6);

    // Abort after 20 steps, with an ignored start mid-run
    wr(A_CNT, 100);
    s0 = step_cnt; c0 = clr_cnt;
    wr(A_CTRL, 32'h1);
    lim = 0;
    while ((step_cnt - s0) < 5 && lim < 200) begin @(negedge clk); lim++; end
    wr(A_CTRL, 32'h1);
    while ((step_cnt - s0) < 19 && lim < 200) begin @(negedge clk); lim++; end
    check("abort_reach19", step_cnt - s0, 32'd19);
    wr(A_CTRL, 32'h2);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_step", {31'd0, fib_step}, 32'd0);
    rd(A_STEP, v);  check("abort_steps_reg", v, 32'd20);
    check("abort_steps_seen", step_cnt - s0, 32'd20);
    check("abort_clears", clr_cnt - c0, 32'd1);
    rd(A_STAT, v);  check("abort_status", v, 32'd0);
    rd(A_RES, v);   check("abort_result_hold", v, 32'd512559680);
    $display("abort: steps=20 result held");

    // Interrupt, W1C, and W1C coincident with CAPTURE
    run_check(5, 1'b1, "irq5");
    rd(A_RES, v); check("irq5_result_const", v, 32'd5);
    wr(A_STAT, 32'h2);
    check("w1c_irq", {31'd0, done_irq}, 32'd0);
    rd(A_STAT, v); check("w1c_status", v, 32'd0);
    wr(A_CNT, 0);
    wr(A_CTRL, 32'h5);
    wr(A_STAT, 32'h2);
    check("coinc_irq", {31'd0, done_irq}, 32'd1);
    rd(A_STAT, v); check("coinc_status", v, 32'h2);
    $display("irq: w1c clears, coincident clear loses to set");

    // Random runs and COUNT readback
    for (int t = 0; t < 6; t++) begin
      rnd = $urandom;
      wr(A_CNT, rnd);
      rd(A_CNT, v);
      check("count_readback", v, {16'd0, rnd[15:0]});
      n = $urandom_range(70, 0);
      run_check(n, rnd[20], "rand");
    end

    // Reset mid-run
    wr(A_CNT, 100);
    wr(A_CTRL, 32'h5);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_ack", {31'd0, wbs_ack_o}, 32'd0);
    check("mrst_dat", wbs_dat_o, 32'd0);
    check("mrst_clear", {31'd0, fib_clear}, 32'd0);
    check("mrst_step", {31'd0, fib_step}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_irq", {31'd0, done_irq}, 32'd0);
    b0 = busy_cnt;
    repeat (4) @(posedge clk);
    #1;
    check("mrst_stays_idle", busy_cnt - b0, 32'd0);
    rd(A_STAT, v); check("mrst_status", v, 32'd0);
    rd(A_RES, v);  check("mrst_result", v, 32'd0);
    rd(A_STEP, v); check("mrst_steps", v, 32'd0);
    rd(32'h20, v); check("unmapped_read", v, 32'd0);
    wr(32'h20, 32'h0000_FFFF);
    rd(A_CNT, v);  check("unmapped_write_dropped", v, 32'd0);
    $display("reset mid-run: outputs cleared, unmapped read 0");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fib_sequencer.md
# fib_sequencer

Wishbone-controlled sequencer for the fibonacci datapath in the user project area. Software programs a term count, starts a run, and the block clears the datapath, steps it exactly N times, captures the resulting term and flags completion or arithmetic wrap. It sits between the Caravel Wishbone slave port and the fibonacci core, replacing free-running operation with deterministic, software-controlled runs.

## Interface
- WIDTH, 32: datapath width, 2..32; RESULT zero-extended to 32 bits.
- BASE_ADDR, 32'h3000_0000: Wishbone base; registers at BASE_ADDR + 0x00..0x10.
- clk  in  1  system clock (wb_clk_i at top level).
- reset  in  1  synchronous, active-high reset.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe/cycle/write.
- wbs_sel_i  in  4  ignored; all writes are full-word.
- wbs_adr_i, wbs_dat_i  in  32 each  address / write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data, valid while ack high, else 0.
- fib_clear  out  1  datapath clear: on that edge, value <= 0, next term <= 1.
- fib_step  out  1  datapath advance one term per cycle high.
- fib_value  in  WIDTH  registered datapath term.
- busy  out  1  run in progress.
- done_irq  out  1  level interrupt = STATUS.done & CTRL.irq_en.

## Operation
- Registers: 0x00 CTRL (bit0 start W1P, bit1 abort W1P, bit2 irq_en RW; reads bit2 only). 0x04 COUNT (bits15:0 RW, upper read 0). 0x08 STATUS (bit0 busy RO, bit1 done W1C, bit2 overflow W1C). 0x0C RESULT RO. 0x10 STEPS RO (steps issued in last/current run, 16 bits).
- Unmapped offsets: acked, read 0, writes dropped.
- FSM IDLE -> CLEAR -> RUN -> CAPTURE -> IDLE.
- IDLE: start write -> CLEAR; clears STEPS, done, overflow.
- CLEAR: fib_clear=1 one cycle; -> RUN, or -> CAPTURE when COUNT==0.
- RUN: fib_step=1 each cycle, STEPS++; exits to CAPTURE after COUNT steps. COUNT sampled at start; writes during a run do not affect it.
- Overflow: in RUN and CAPTURE, fib_value < previous-cycle fib_value sets overflow (sticky; Fibonacci never decreases, so any drop is a wrap).
- CAPTURE: RESULT <= fib_value; done <= 1; -> IDLE.
- Abort write in any non-IDLE state -> IDLE next edge; RESULT and done unchanged, STEPS holds progress.
- Start while busy: ignored. Start and abort in the same write: abort wins (no-op from IDLE).
- W1C of done in the same cycle CAPTURE sets it: set wins.
- Reset: all registers, outputs, FSM to 0/IDLE; mid-run reset abandons the run with no done.

## Timing
- Wishbone: stb&cyc&!ack at edge k -> ack=1 during cycle k+1, then 0; one transfer per two cycles minimum. Register writes take effect on edge k.
- Start accepted at edge k: busy=1 from k; fib_clear high in cycle k+1; fib_step high cycles k+2..k+1+N; CAPTURE in cycle k+2+N; RESULT, done valid and busy=0 from edge k+3+N.
- busy high N+2 cycles (2 for N=0).
- done_irq combinational from registered bits, no extra latency.
- Reset values: wbs_ack_o=0, wbs_dat_o=0, fib_clear=0, fib_step=0, busy=0, done_irq=0.

## Test plan
- COUNT=10, start -> fib_step high exactly 10 cycles, busy 12 cycles, RESULT=55, STEPS=10, done=1, overflow=0.
- COUNT=0, start -> one fib_clear pulse, no fib_step, RESULT=0, done=1 after 2 busy cycles.
- WIDTH=32: COUNT=47 -> RESULT=2971215073, overflow=0; COUNT=48 -> RESULT=512559680, overflow=1.
- COUNT=100, abort after 20 steps -> busy=0 next cycle, STEPS=20, done=0, RESULT holds prior value; second start during run ignored.
- irq_en=1, run COUNT=5 -> done_irq rises with done, RESULT=5; W1C STATUS bit1 -> done_irq=0; clear coincident with CAPTURE -> done stays 1.
- Reset asserted mid-run and unmapped read at BASE_ADDR+0x20 -> all outputs 0, FSM IDLE; read acked with 0x0.
